// File: rtl/seq_state_reg_p2.sv
// Detector for the serial pattern 1101 with a post-detect hold window.
// The hold length comes from an external down-stream cleared up-counter.
module seq_state_reg_p2 #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w,
  input  logic       counter_rst,
  output logic [2:0] state,
  output logic [3:0] count,
  output logic       detect
);

  // state | meaning
  // S0    | idle, nothing matched
  // S1    | seen "1"
  // S2    | seen "11" (further 1s keep us here)
  // S3    | seen "110"
  // S4    | hold after "1101"; leaves on timeout
  // other | illegal, recovers to S0
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       detect_q, detect_d;
  logic       timeout;

  assign timeout = (state_q == S4) && (count_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S0;
      count_q  <= 4'd0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      detect_q <= detect_d;
    end
  end

  always_comb begin
    state_d  = S0;
    detect_d = 1'b0;
    case (state_q)
      S0: state_d = w ? S1 : S0;
      S1: state_d = w ? S2 : S0;
      S2: state_d = w ? S2 : S3;
      S3: begin
        if (w) begin
          state_d  = S4;
          detect_d = 1'b1;
        end else begin
          state_d = S0;
        end
      end
      S4:      state_d = timeout ? S0 : S4;
      default: state_d = S0;
    endcase
  end

  // Clear wins over increment; saturate rather than wrap.
  always_comb begin
    count_d = count_q;
    if (counter_rst)
      count_d = 4'd0;
    else if (count_q != 4'hF)
      count_d = count_q + 4'd1;
  end

  assign state  = state_q;
  assign count  = count_q;
  assign detect = detect_q;

endmodule

// File: tb/tb_seq_state_reg_p2.sv
// Scoreboard bench for seq_state_reg_p2: a pattern-matching reference model
// predicts each edge's outputs; a monitor compares them after the edge.
module tb_seq_state_reg_p2;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       w;
  logic       counter_rst;
  logic [2:0] state;
  logic [3:0] count;
  logic       detect;

  seq_state_reg_p2 #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .w           (w),
    .counter_rst (counter_rst),
    .state       (state),
    .count       (count),
    .detect      (detect)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] cnt;
    logic       det;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: matched prefix length of "1101", hold flag, counter.
  bit   hist[$];
  bit   pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit   m_hold = 1'b0;
  int   m_prog = 0;
  int   m_cnt  = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int match_len();
    int best = 0;
    for (int k = 1; k <= 4; k++) begin
      bit ok = (hist.size() >= k);
      if (ok)
        for (int i = 0; i < k; i++)
          if (hist[hist.size() - k + i] != pat[i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_hold = 1'b0;
    m_prog = 0;
    m_cnt  = 0;
  endtask

  // Inputs are already applied; predict the outputs after the coming edge.
  task automatic model_push(input bit wi, input bit cr);
    exp_t e;
    bit   det = 1'b0;
    if (m_hold) begin
      if (m_cnt == HOLD - 1) begin
        m_hold = 1'b0;
        m_prog = 0;
        hist.delete();
      end
    end else begin
      int k;
      hist.push_back(wi);
      while (hist.size() > 4) void'(hist.pop_front());
      k = match_len();
      if (k == 4) begin
        m_hold = 1'b1;
        det    = 1'b1;
        m_prog = 0;
        hist.delete();
      end else begin
        m_prog = k;
      end
    end
    m_cnt = cr ? 0 : ((m_cnt < 15) ? m_cnt + 1 : 15);
    e.st  = m_hold ? 3'd4 : 3'(m_prog);
    e.cnt = 4'(m_cnt);
    e.det = det;
    sbq.push_back(e);
  endtask

  task automatic drive_now(input bit wi, input bit cr);
    w = wi;
    counter_rst = cr;
    model_push(wi, cr);
  endtask

  task automatic step(input bit wi, input bit cr);
    @(negedge clk);
    drive_now(wi, cr);
  endtask

  // counter_rst as the downstream decoder would drive it.
  task automatic step_dec(input bit wi);
    step(wi, !m_hold);
  endtask

  task automatic seq(input bit b0, input bit b1, input bit b2, input bit b3);
    step_dec(b0); step_dec(b1); step_dec(b2); step_dec(b3);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("state", int'(state), int'(e.st));
        check("count", int'(count), int'(e.cnt));
        check("detect", int'(detect), int'(e.det));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    w = 1'b0;
    counter_rst = 1'b0;
    #3;
    check("reset_state", int'(state), 0);
    check("reset_count", int'(count), 0);
    check("reset_detect", int'(detect), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_now(1'b1, 1'b1);

    // 1101 detect (first 1 already applied), then the full hold window
    step_dec(1'b1); step_dec(1'b0); step_dec(1'b1);
    repeat (10) step_dec(1'($urandom_range(0, 1)));

    // overlap: repeated 1s stay in S2
    seq(1, 1, 1, 1); step_dec(1'b0); step_dec(1'b1);
    repeat (9) step_dec(1'b0);

    // abort without detect
    seq(1, 1, 0, 0);

    // clear held during S4 keeps the hold alive
    seq(1, 1, 0, 1);
    repeat (12) step(1'($urandom_range(0, 1)), 1'b1);
    repeat (9) step_dec(1'b0);

    // saturation
    repeat (20) step(1'b0, 1'b0);
    step_dec(1'b0);

    // random traffic, decoder-like counter_rst with occasional flips
    repeat (1500) begin
      bit cr = m_hold ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      step(1'($urandom_range(0, 1)), cr);
    end
    repeat (12) step_dec(1'b0);

    // async reset mid-hold, count=5
    seq(1, 1, 0, 1);
    repeat (5) step_dec(1'b0);
    @(negedge clk);
    check("pre_rst_state", int'(state), 4);
    check("pre_rst_count", int'(count), 5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_count", int'(count), 0);
    check("async_rst_detect", int'(detect), 0);
    #1 rst = 1'b0;
    model_reset();
    drive_now(1'b1, 1'b1);
    step_dec(1'b0);

    // illegal-state recovery for both values of w
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      force dut.state_q = 3'b110;
      #1;
      release dut.state_q;
      w = 1'(i);
      counter_rst = 1'b1;
      if (state == 3'b110) begin
        exp_t e;
        model_reset();
        e.st = 3'd0; e.cnt = 4'd0; e.det = 1'b0;
        sbq.push_back(e);
      end else begin
        model_push(1'(i), 1'b1);
      end
    end
    step_dec(1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
